// File: rtl/path_delay_tester.sv
// Launch/capture path delay tester: toggles a launch signal, samples the path
// output a programmable number of cycles later and counts mismatching trials.
module path_delay_tester #(
  parameter int CNT_W  = 16,
  parameter int DLY_W  = 4,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] trials,
  input  logic [DLY_W-1:0] captureDelay,
  input  logic             pathResult,
  output logic             pathInput,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] errorCount,
  output logic             lastSample
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] trials_r;
  logic [DLY_W-1:0] delay_r;
  logic [DLY_W-1:0] wait_cnt_r;
  logic [7:0]       settle_cnt_r;
  logic             path_input_r;
  logic [CNT_W-1:0] error_count_r;
  logic             last_sample_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             busy_n;

  assign accept_s = start && (trials != {CNT_W{1'b0}});

  // Next-state decode
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_n = ST_LAUNCH;
        else          state_n = ST_IDLE;
      end
      ST_LAUNCH: begin
        if (delay_r != {DLY_W{1'b0}}) state_n = ST_WAIT;
        else                          state_n = ST_CAPTURE;
      end
      ST_WAIT: begin
        if (wait_cnt_r == DLY_W'(1)) state_n = ST_CAPTURE;
        else                         state_n = ST_WAIT;
      end
      ST_CAPTURE: state_n = ST_RECOVER;
      ST_RECOVER: begin
        if (settle_cnt_r == 8'd1) begin
          if (trials_r == CNT_W'(1)) state_n = ST_DONE;
          else                       state_n = ST_LAUNCH;
        end else begin
          state_n = ST_RECOVER;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy_n = (state_n == ST_LAUNCH) || (state_n == ST_WAIT) ||
                  (state_n == ST_CAPTURE) || (state_n == ST_RECOVER);

  // State register with busy/done registered alongside it so they track the state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= busy_n;
      done_r  <= (state_n == ST_DONE);
    end
  end

  // Datapath: run parameters, counters, launch signal and capture/compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trials_r      <= {CNT_W{1'b0}};
      delay_r       <= {DLY_W{1'b0}};
      wait_cnt_r    <= {DLY_W{1'b0}};
      settle_cnt_r  <= 8'd0;
      path_input_r  <= 1'b0;
      error_count_r <= {CNT_W{1'b0}};
      last_sample_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            trials_r      <= trials;
            delay_r       <= captureDelay;
            error_count_r <= {CNT_W{1'b0}};
          end
        end
        ST_LAUNCH: begin
          path_input_r <= ~path_input_r;
          wait_cnt_r   <= delay_r;
        end
        ST_WAIT: begin
          wait_cnt_r <= wait_cnt_r - DLY_W'(1);
        end
        ST_CAPTURE: begin
          // path_input_r still holds the value launched for this trial
          last_sample_r <= pathResult;
          settle_cnt_r  <= SETTLE_CNT;
          if (pathResult != path_input_r) error_count_r <= error_count_r + CNT_W'(1);
        end
        ST_RECOVER: begin
          settle_cnt_r <= settle_cnt_r - 8'd1;
          if (settle_cnt_r == 8'd1) trials_r <= trials_r - CNT_W'(1);
        end
        ST_DONE: begin
          trials_r <= trials_r;
        end
        default: begin
          trials_r <= trials_r;
        end
      endcase
    end
  end

  assign pathInput  = path_input_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign errorCount = error_count_r;
  assign lastSample = last_sample_r;

endmodule
